// File: rtl/rect_fetch.sv
// Rectangle descriptor fetcher: reads four consecutive ROM words for a feature
// index and presents them as one {x,y,w,h} descriptor under valid/ready.
module rect_fetch #(
  parameter int W_DATA = 5,
  parameter int W_ADDR = 14,
  parameter int W_FEAT = 12,
  parameter int N_FEAT = 52,
  parameter int WIN_W  = 24,
  parameter int WIN_H  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [W_FEAT-1:0] req_feat,
  output logic              rom_en,
  output logic [W_ADDR-1:0] rom_addr,
  input  logic [W_DATA-1:0] rom_data,
  output logic              rect_valid,
  input  logic              rect_ready,
  output logic [W_DATA-1:0] rect_x,
  output logic [W_DATA-1:0] rect_y,
  output logic [W_DATA-1:0] rect_w,
  output logic [W_DATA-1:0] rect_h,
  output logic              rect_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD} state_t;

  localparam logic [W_FEAT-1:0] N_FEAT_L = W_FEAT'(N_FEAT);
  localparam logic [W_DATA:0]   WIN_W_L  = (W_DATA+1)'(WIN_W);
  localparam logic [W_DATA:0]   WIN_H_L  = (W_DATA+1)'(WIN_H);

  state_t              state_q, state_d;
  logic [1:0]          iss_q, iss_d;
  logic [1:0]          cap_q, cap_d;
  logic                rom_en_q, rom_en_d;
  logic [W_ADDR-1:0]   rom_addr_q, rom_addr_d;
  logic                rect_valid_q, rect_valid_d;
  logic                rect_err_q, rect_err_d;
  logic [W_DATA-1:0]   rect_x_q, rect_x_d;
  logic [W_DATA-1:0]   rect_y_q, rect_y_d;
  logic [W_DATA-1:0]   rect_w_q, rect_w_d;
  logic [W_DATA-1:0]   rect_h_q, rect_h_d;

  logic [W_ADDR-1:0]   feat_addr;
  logic [W_DATA:0]     sum_xw;
  logic [W_DATA:0]     sum_yh;
  logic                capture;

  assign feat_addr = W_ADDR'(req_feat) << 2;
  // h is still on rom_data during DRAIN, so the y+h bound uses it directly
  assign sum_xw    = {1'b0, rect_x_q} + {1'b0, rect_w_q};
  assign sum_yh    = {1'b0, rect_y_q} + {1'b0, rom_data};

  always_comb begin
    state_d      = state_q;
    iss_d        = iss_q;
    cap_d        = cap_q;
    rom_en_d     = rom_en_q;
    rom_addr_d   = rom_addr_q;
    rect_valid_d = rect_valid_q;
    rect_err_d   = rect_err_q;
    rect_x_d     = rect_x_q;
    rect_y_d     = rect_y_q;
    rect_w_d     = rect_w_q;
    rect_h_d     = rect_h_q;
    capture      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_feat < N_FEAT_L) begin
            state_d    = S_FETCH;
            rom_en_d   = 1'b1;
            rom_addr_d = feat_addr;
            iss_d      = '0;
            cap_d      = '0;
          end else begin
            state_d      = S_HOLD;
            rect_x_d     = '0;
            rect_y_d     = '0;
            rect_w_d     = '0;
            rect_h_d     = '0;
            rect_err_d   = 1'b1;
            rect_valid_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        capture = (iss_q != 2'd0);
        if (iss_q == 2'd3) begin
          rom_en_d = 1'b0;
          state_d  = S_DRAIN;
        end else begin
          rom_addr_d = rom_addr_q + W_ADDR'(1);
          iss_d      = iss_q + 2'd1;
        end
      end
      S_DRAIN: begin
        capture      = 1'b1;
        rect_err_d   = (sum_xw > WIN_W_L) | (sum_yh > WIN_H_L);
        rect_valid_d = 1'b1;
        state_d      = S_HOLD;
      end
      S_HOLD: begin
        if (rect_ready) begin
          rect_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      case (cap_q)
        2'd0:    rect_x_d = rom_data;
        2'd1:    rect_y_d = rom_data;
        2'd2:    rect_w_d = rom_data;
        default: rect_h_d = rom_data;
      endcase
      cap_d = cap_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      iss_q        <= '0;
      cap_q        <= '0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      rect_valid_q <= 1'b0;
      rect_err_q   <= 1'b0;
      rect_x_q     <= '0;
      rect_y_q     <= '0;
      rect_w_q     <= '0;
      rect_h_q     <= '0;
    end else begin
      state_q      <= state_d;
      iss_q        <= iss_d;
      cap_q        <= cap_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      rect_valid_q <= rect_valid_d;
      rect_err_q   <= rect_err_d;
      rect_x_q     <= rect_x_d;
      rect_y_q     <= rect_y_d;
      rect_w_q     <= rect_w_d;
      rect_h_q     <= rect_h_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rom_en     = rom_en_q;
  assign rom_addr   = rom_addr_q;
  assign rect_valid = rect_valid_q;
  assign rect_err   = rect_err_q;
  assign rect_x     = rect_x_q;
  assign rect_y     = rect_y_q;
  assign rect_w     = rect_w_q;
  assign rect_h     = rect_h_q;

endmodule

// File: tb/tb_rect_fetch.sv
// Bench for rect_fetch: registered ROM model, queued expectations for ROM
// addresses and descriptors, and a negedge monitor that consumes them.
module tb_rect_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_feat = '0;
  logic        rom_en;
  logic [13:0] rom_addr;
  logic [4:0]  rom_data = '0;
  logic        rect_valid;
  logic        rect_ready = 1'b1;
  logic [4:0]  rect_x, rect_y, rect_w, rect_h;
  logic        rect_err;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  logic        prev_valid = 1'b0;

  typedef struct {
    logic [13:0] addr;
    int unsigned cyc;
  } addr_t;

  typedef struct {
    logic [4:0]  x, y, w, h;
    logic        err;
    int unsigned vcyc;
  } rect_t;

  addr_t exp_addr[$];
  rect_t exp_rect[$];
  logic [4:0] mem [0:255];

  rect_fetch #(.W_DATA(5), .W_ADDR(14), .W_FEAT(12), .N_FEAT(52), .WIN_W(24), .WIN_H(24)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_feat(req_feat),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rect_valid(rect_valid), .rect_ready(rect_ready),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_err(rect_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Outside read cycles the ROM output is scrambled so stray captures show up
  always @(posedge clk) begin
    if (rom_en) rom_data <= mem[rom_addr[7:0]];
    else        rom_data <= 5'($urandom);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rom_en) begin
        if (exp_addr.size() == 0) begin
          chk("unexpected_rom_en", 1, 0);
        end else begin
          addr_t a;
          a = exp_addr.pop_front();
          chk("rom_addr", rom_addr, a.addr);
          chk("rom_en_cycle", cyc, a.cyc);
        end
      end
      if (rect_valid && !prev_valid) begin
        if (exp_rect.size() == 0) chk("unexpected_rect_valid", 1, 0);
        else                      chk("rect_valid_cycle", cyc, exp_rect[0].vcyc);
      end
      if (rect_valid && rect_ready && exp_rect.size() != 0) begin
        rect_t r;
        r = exp_rect.pop_front();
        chk("rect_x", rect_x, r.x);
        chk("rect_y", rect_y, r.y);
        chk("rect_w", rect_w, r.w);
        chk("rect_h", rect_h, r.h);
        chk("rect_err", rect_err, r.err);
      end
    end
    prev_valid <= rect_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int feat, input logic [4:0] x, y, w, h, input logic e);
    rect_t r;
    int unsigned c;
    c = cyc;
    chk("req_ready_before_issue", req_ready, 1);
    req_valid = 1'b1;
    req_feat  = 12'(feat);
    if (feat < 52) begin
      for (int unsigned k = 0; k < 4; k++) begin
        addr_t a;
        a.addr = 14'(feat * 4 + int'(k));
        a.cyc  = c + 1 + k;
        exp_addr.push_back(a);
      end
      r.vcyc = c + 6;
    end else begin
      r.vcyc = c + 1;
    end
    r.x = x; r.y = y; r.w = w; r.h = h; r.err = e;
    exp_rect.push_back(r);
    step(1);
    req_valid = 1'b0;
    req_feat  = 12'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 5'd6;   mem[1] = 5'd4;   mem[2] = 5'd12;  mem[3] = 5'd9;
    mem[4] = 5'd20;  mem[5] = 5'd1;   mem[6] = 5'd12;  mem[7] = 5'd2;
    mem[8] = 5'd3;   mem[9] = 5'd20;  mem[10] = 5'd4;  mem[11] = 5'd5;
    mem[12] = 5'd0;  mem[13] = 5'd10; mem[14] = 5'd0;  mem[15] = 5'd14;
    mem[48] = 5'd0;  mem[49] = 5'd2;  mem[50] = 5'd24; mem[51] = 5'd3;
    mem[204] = 5'd1; mem[205] = 5'd2; mem[206] = 5'd3; mem[207] = 5'd4;

    step(3);
    rst = 1'b0;
    chk("reset_rom_en", rom_en, 0);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_rect_valid", rect_valid, 0);
    chk("reset_rect_err", rect_err, 0);
    chk("reset_rect_xywh", {rect_x, rect_y, rect_w, rect_h}, 0);
    chk("reset_req_ready", req_ready, 1);

    issue(0, 5'd6, 5'd4, 5'd12, 5'd9, 1'b0);   step(8);
    issue(12, 5'd0, 5'd2, 5'd24, 5'd3, 1'b0);  step(8);
    issue(52, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1);   step(3);
    issue(4095, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1); step(3);
    issue(1, 5'd20, 5'd1, 5'd12, 5'd2, 1'b1);  step(8);
    issue(2, 5'd3, 5'd20, 5'd4, 5'd5, 1'b1);   step(8);
    issue(3, 5'd0, 5'd10, 5'd0, 5'd14, 1'b0);  step(8);
    issue(51, 5'd1, 5'd2, 5'd3, 5'd4, 1'b0);   step(8);

    rect_ready = 1'b0;
    issue(0, 5'd6, 5'd4, 5'd12, 5'd9, 1'b0);
    begin
      int unsigned n = 0;
      while (!rect_valid && n < 20) begin
        step(1);
        n++;
      end
      chk("hold_valid_seen", rect_valid, 1);
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_valid", rect_valid, 1);
      chk("hold_data", {rect_x, rect_y, rect_w, rect_h, rect_err}, {5'd6, 5'd4, 5'd12, 5'd9, 1'b0});
      chk("hold_req_ready", req_ready, 0);
      chk("hold_rom_en", rom_en, 0);
    end
    rect_ready = 1'b1;
    step(1);
    chk("after_take_valid", rect_valid, 0);
    chk("after_take_req_ready", req_ready, 1);
    step(2);

    issue(0, 5'd6, 5'd4, 5'd12, 5'd9, 1'b0);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_rom_en", rom_en, 0);
    chk("abort_rect_valid", rect_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    exp_addr.delete();
    exp_rect.delete();
    issue(0, 5'd6, 5'd4, 5'd12, 5'd9, 1'b0);   step(8);

    chk("pending_addr_left", exp_addr.size(), 0);
    chk("pending_rect_left", exp_rect.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
